// File: rtl/mul_sequencer_pkg.sv
// ============================================================================
// mul_sequencer_pkg : shared state encoding and size defaults for the
//                     iterative shift-add multiplier.
// Revision 1.0
// ============================================================================
`default_nettype none

package mul_sequencer_pkg;

  localparam int C_WIDTH_DEFAULT = 32;
  localparam int C_CNT_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/mul_datapath.sv
// ============================================================================
// mul_datapath : operand shift registers, accumulator adder and the
//                registered result/flags of the shift-add multiplier.
// Revision 1.0
// ============================================================================
`default_nettype none

module mul_datapath
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = C_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             finish,
  input  logic             mul_acc,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       flags
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       flags_q, flags_d;
  logic [WIDTH-1:0] w_sum;

  // Partial-product add for the current iteration; wraps modulo 2^WIDTH.
  assign w_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (load) begin
      mcand_d  = src_a;
      mplier_d = src_b;
      acc_d    = mul_acc ? acc_in : '0;
    end else if (step) begin
      acc_d    = w_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
    // The final iteration's sum goes straight to the output register.
    if (finish) begin
      result_d = w_sum;
      flags_d  = {w_sum[WIDTH-1], (w_sum == '0)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

`default_nettype wire

// File: rtl/mul_sequencer.sv
// ============================================================================
// mul_sequencer : FSM and iteration counter driving a WIDTH-cycle shift-add
//                 MUL/MLA, with pipeline stall and done-pulse handshake.
// Revision 1.0
// ============================================================================
`default_nettype none

module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = C_WIDTH_DEFAULT,
  parameter int CNT_W = C_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic             MulAccE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [WIDTH-1:0] AccE,
  input  logic             FlushE,
  output logic             StallMul,
  output logic             DoneM,
  output logic [WIDTH-1:0] ResultM,
  output logic [1:0]       MulFlagsM
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_load;
  logic             w_step;
  logic             w_finish;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    StallMul = 1'b0;
    DoneM    = 1'b0;
    case (state_q)
      IDLE: begin
        if (StartE && !FlushE) begin
          StallMul = 1'b1;
          w_load   = 1'b1;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        StallMul = 1'b1;
        if (FlushE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          w_step = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            w_finish = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        DoneM   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .step    (w_step),
    .finish  (w_finish),
    .mul_acc (MulAccE),
    .src_a   (SrcAE),
    .src_b   (SrcBE),
    .acc_in  (AccE),
    .result  (ResultM),
    .flags   (MulFlagsM)
  );

endmodule

`default_nettype wire

// File: tb/tb_mul_sequencer.sv
// ============================================================================
// tb_mul_sequencer : directed self-checking bench for mul_sequencer.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mul_sequencer;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             StartE;
  logic             MulAccE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic [WIDTH-1:0] AccE;
  logic             FlushE;
  logic             StallMul;
  logic             DoneM;
  logic [WIDTH-1:0] ResultM;
  logic [1:0]       MulFlagsM;

  int               n_vec = 0;
  int               n_err = 0;
  logic             busy;
  logic [WIDTH-1:0] last_res;
  logic [1:0]       last_flags;

  mul_sequencer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .StartE    (StartE),
    .MulAccE   (MulAccE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .AccE      (AccE),
    .FlushE    (FlushE),
    .StallMul  (StallMul),
    .DoneM     (DoneM),
    .ResultM   (ResultM),
    .MulFlagsM (MulFlagsM)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent occupancy model; StartE while occupied breaks the stall protocol.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      assert (!(busy && StartE)) else $error("protocol: StartE while multiplier occupied");
      if (!busy && StartE && !FlushE) busy <= 1'b1;
      else if (busy && (DoneM || (FlushE && StallMul))) busy <= 1'b0;
    end
  end

  task automatic run_op(input string tag, input logic mla, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] acc,
                        input logic [31:0] exp_r, input logic [1:0] exp_f);
    int n;
    int stalls;
    bit seen;
    @(negedge clk);
    check({tag, "_nodone_pre"}, DoneM, 0);
    StartE  = 1'b1;
    MulAccE = mla;
    SrcAE   = a;
    SrcBE   = b;
    AccE    = acc;
    #1;
    check({tag, "_stall_start"}, StallMul, 1);
    stalls = 1;
    seen   = 0;
    n      = 0;
    @(negedge clk);
    n++;
    StartE  = 1'b0;
    MulAccE = ~mla;
    SrcAE   = ~a;
    SrcBE   = ~b;
    AccE    = ~acc;
    while (!seen && n < 60) begin
      if (DoneM) begin
        seen = 1;
      end else begin
        if (StallMul) stalls++;
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_latency"}, n, 33);
    check({tag, "_stall_cycles"}, stalls, 33);
    check({tag, "_stall_done"}, StallMul, 0);
    check({tag, "_result"}, ResultM, exp_r);
    check({tag, "_flags"}, MulFlagsM, exp_f);
    last_res   = exp_r;
    last_flags = exp_f;
  endtask

  initial begin
    int dones;
    int n;
    reset   = 1'b1;
    StartE  = 1'b0;
    MulAccE = 1'b0;
    SrcAE   = '0;
    SrcBE   = '0;
    AccE    = '0;
    FlushE  = 1'b0;
    #1;
    check("rst_stall", StallMul, 0);
    check("rst_done", DoneM, 0);
    check("rst_result", ResultM, 0);
    check("rst_flags", MulFlagsM, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 32'h55, 32'd42, 2'b00);
    run_op("mla_wrap", 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'h0000_0001, 2'b00);
    run_op("mul_neg", 1'b0, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000, 2'b10);
    run_op("mul_zero", 1'b0, 32'd5, 32'd0, 32'd9, 32'd0, 2'b01);
    run_op("mul_m2x3", 1'b0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'hFFFF_FFFA, 2'b10);

    // Flush in the tenth RUN cycle.
    @(negedge clk);
    StartE = 1'b1; MulAccE = 1'b0; SrcAE = 32'd7; SrcBE = 32'd9; AccE = '0;
    @(negedge clk);
    StartE = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    FlushE = 1'b1;
    #1;
    check("flush_stall_run", StallMul, 1);
    @(negedge clk);
    FlushE = 1'b0;
    #1;
    check("flush_stall_drop", StallMul, 0);
    check("flush_nodone", DoneM, 0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (DoneM) dones++;
    end
    check("flush_no_pulse", dones, 0);
    check("flush_result_held", ResultM, last_res);
    check("flush_flags_held", MulFlagsM, last_flags);

    // Start together with flush in IDLE is dropped.
    @(negedge clk);
    StartE = 1'b1; FlushE = 1'b1; SrcAE = 32'd3; SrcBE = 32'd4;
    #1;
    check("idleflush_stall", StallMul, 0);
    @(negedge clk);
    StartE = 1'b0; FlushE = 1'b0;
    #1;
    check("idleflush_stays_idle", StallMul, 0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (DoneM) dones++;
    end
    check("idleflush_no_pulse", dones, 0);
    check("idleflush_result_held", ResultM, last_res);

    // Reset in the middle of RUN.
    @(negedge clk);
    StartE = 1'b1; MulAccE = 1'b0; SrcAE = 32'hFFFF; SrcBE = 32'hFFFF;
    @(negedge clk);
    StartE = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_stall", StallMul, 0);
    check("midrst_done", DoneM, 0);
    check("midrst_result", ResultM, 0);
    check("midrst_flags", MulFlagsM, 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (DoneM) dones++;
    end
    check("midrst_no_pulse", dones, 0);
    run_op("mul_3x3", 1'b0, 32'd3, 32'd3, 32'd0, 32'd9, 2'b00);

    // Issued in the cycle right after the previous DoneM.
    run_op("b2b_mla", 1'b1, 32'h1234_5678, 32'h10, 32'd8, 32'h2345_6788, 2'b00);
    run_op("b2b_m1xm1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 2'b00);

    @(negedge clk);
    check("final_nodone", DoneM, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
